// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the unified-memory arbiter, its two
// requesters (instruction fetch and the data-memory stage) and the single
// backing-memory port.
//   slave  : arbiter view. It takes requests and memory responses, and drives
//            the responses, stalls and backing-memory request.
//   master : environment view (pipeline + memory). This is the mirror image
//            of the slave view.
// Request fields must be held stable until the matching valid pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    // backing memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid, if_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid, if_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported backing memory between instruction fetch and the
// data-memory stage. Only one transaction is in flight at a time. Data wins
// a conflict unless fetch has been passed over STARVE_MAX times in a row.
// Responses are combinational in the mem_ack cycle, and an IDLE bubble always
// separates two transactions.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data and backing-memory signals)
// The interface ADDR_W/DATA_W must match the parameters of this module.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              discard;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic want_i;
    logic force_i;
    logic grant_d;
    logic grant_i;

    always_comb begin
        // A flushed fetch is not a candidate this cycle.
        want_i  = bus.if_req && !bus.if_flush;
        force_i = want_i && (starve_cnt == CNT_MAX);
        grant_d = bus.d_req && !force_i;
        grant_i = want_i && !grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            discard    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= BUSY_D;
                        we_q    <= bus.d_we;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        // Fetch was waiting and lost: count it, saturating.
                        if (want_i && starve_cnt != CNT_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_i) begin
                        state      <= BUSY_I;
                        we_q       <= 1'b0;
                        addr_q     <= bus.if_addr;
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    // Memory cannot abort: a flushed fetch runs to its ack and
                    // the response is swallowed.
                    if (bus.mem_ack) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (bus.if_flush) begin
                        discard <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory request follows the state register directly, so it is glitch-free.
    assign bus.mem_req   = (state != IDLE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // A stray ack in IDLE never matches a BUSY state, so it is ignored.
    assign bus.if_valid = (state == BUSY_I) && bus.mem_ack && !discard && !bus.if_flush;
    assign bus.if_rdata = bus.mem_rdata;
    assign bus.d_valid  = (state == BUSY_D) && bus.mem_ack;
    assign bus.d_rdata  = bus.mem_rdata;

    assign bus.if_stall = bus.if_req && !bus.if_valid;
    assign bus.d_stall  = bus.d_req && !bus.d_valid;
endmodule
